// File: rtl/pim_host_frontend.sv
// rtl/pim_host_frontend.sv - host word FIFO and dispatcher onto pim_system command, microprogram and execute ports
// Tagged host words are popped in order; microprogram words are packed into one wide program before hand-off.
module pim_host_frontend #(
  parameter int CMD_SIZE_BITS       = 64,
  parameter int MICROPROG_LEN_WORDS = 4,
  parameter int HOST_FIFO_DEPTH     = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         host_valid,
  output logic                                         host_ready,
  input  logic [1:0]                                   host_kind,
  input  logic [CMD_SIZE_BITS-1:0]                     host_word,
  output logic                                         cpu_cmd_valid,
  output logic [CMD_SIZE_BITS-1:0]                     cpu_cmd_data,
  input  logic                                         cpu_cmd_ready,
  output logic                                         cpu_microprog_valid,
  output logic [CMD_SIZE_BITS*MICROPROG_LEN_WORDS-1:0] cpu_microprog_data,
  input  logic                                         cpu_microprog_ack,
  output logic                                         cpu_execute_seq_valid,
  input  logic                                         cpu_execute_seq_ready,
  output logic [$clog2(HOST_FIFO_DEPTH):0]             fifo_count,
  output logic                                         frontend_busy,
  output logic [1:0]                                   err_flags
);

  localparam int PW = $clog2(HOST_FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (MICROPROG_LEN_WORDS > 1) ? $clog2(MICROPROG_LEN_WORDS) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(HOST_FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(MICROPROG_LEN_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_PUSH, S_EXEC} state_t;

  state_t                     state, next_state;
  logic [CMD_SIZE_BITS+1:0]   mem [HOST_FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [IW-1:0]              idx;
  logic [1:0]                 head_kind;
  logic [CMD_SIZE_BITS-1:0]   head_word;
  logic                       push, pop;

  assign host_ready            = (fifo_count != FULL_CNT);
  assign push                  = host_valid && host_ready;
  assign {head_kind, head_word} = mem[rd_ptr];

  // Valids come straight from the registered state, so they rise the cycle after the pop.
  assign cpu_cmd_valid         = (state == S_CMD);
  assign cpu_microprog_valid   = (state == S_PUSH);
  assign cpu_execute_seq_valid = (state == S_EXEC);
  assign frontend_busy         = (fifo_count != '0) || (state != S_IDLE);

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (fifo_count != '0) begin
          pop = 1'b1;
          case (head_kind)
            2'b00:   next_state = S_CMD;
            2'b01:   next_state = (idx == LAST_IDX) ? S_PUSH : S_IDLE;
            2'b10:   next_state = S_EXEC;
            default: next_state = S_IDLE;
          endcase
        end
      end
      S_CMD:  if (cpu_cmd_ready)         next_state = S_IDLE;
      S_PUSH: if (cpu_microprog_ack)     next_state = S_IDLE;
      S_EXEC: if (cpu_execute_seq_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {host_kind, host_word};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_count         <= '0;
      idx                <= '0;
      cpu_cmd_data       <= '0;
      cpu_microprog_data <= '0;
      err_flags          <= '0;
    end else begin
      state <= next_state;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (pop) begin
        // A non-microprogram word arriving mid-pack discards the partial program first.
        if (head_kind != 2'b01 && idx != '0) begin
          cpu_microprog_data <= '0;
          idx                <= '0;
          err_flags[0]       <= 1'b1;
        end
        case (head_kind)
          2'b00: cpu_cmd_data <= head_word;
          2'b01: begin
            cpu_microprog_data[int'(idx)*CMD_SIZE_BITS +: CMD_SIZE_BITS] <= head_word;
            idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
          end
          2'b11:   err_flags[1] <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pim_host_frontend.sv
// tb/tb_pim_host_frontend.sv - scoreboard bench for pim_host_frontend
module tb_pim_host_frontend;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         host_valid = 1'b0;
  logic         host_ready;
  logic [1:0]   host_kind = 2'b00;
  logic [63:0]  host_word = '0;
  logic         cpu_cmd_valid;
  logic [63:0]  cpu_cmd_data;
  logic         cpu_cmd_ready = 1'b1;
  logic         cpu_microprog_valid;
  logic [255:0] cpu_microprog_data;
  logic         cpu_microprog_ack = 1'b0;
  logic         cpu_execute_seq_valid;
  logic         cpu_execute_seq_ready = 1'b1;
  logic [3:0]   fifo_count;
  logic         frontend_busy;
  logic [1:0]   err_flags;

  int checks = 0;
  int errors = 0;

  logic [63:0]  cmd_q[$];
  logic [255:0] mp_q[$];
  int           exec_pending = 0;
  logic [255:0] mp_acc = '0;
  int           mp_idx = 0;
  logic [1:0]   exp_err = 2'b00;

  pim_host_frontend dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_ready(host_ready), .host_kind(host_kind), .host_word(host_word),
    .cpu_cmd_valid(cpu_cmd_valid), .cpu_cmd_data(cpu_cmd_data), .cpu_cmd_ready(cpu_cmd_ready),
    .cpu_microprog_valid(cpu_microprog_valid), .cpu_microprog_data(cpu_microprog_data),
    .cpu_microprog_ack(cpu_microprog_ack),
    .cpu_execute_seq_valid(cpu_execute_seq_valid), .cpu_execute_seq_ready(cpu_execute_seq_ready),
    .fifo_count(fifo_count), .frontend_busy(frontend_busy), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [63:0] w);
    int n = 0;
    host_kind = k;
    host_word = w;
    host_valid = 1'b1;
    while (!host_ready && n < 200) begin
      tick();
      n++;
    end
    chk("push_timeout", n < 200, 1);
    if (k != 2'b01 && mp_idx != 0) begin
      mp_acc = '0;
      mp_idx = 0;
      exp_err[0] = 1'b1;
    end
    case (k)
      2'b00: cmd_q.push_back(w);
      2'b01: begin
        mp_acc[mp_idx*64 +: 64] = w;
        mp_idx++;
        if (mp_idx == 4) begin
          mp_q.push_back(mp_acc);
          mp_idx = 0;
        end
      end
      2'b10: exec_pending++;
      default: exp_err[1] = 1'b1;
    endcase
    tick();
    host_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (frontend_busy && n < 200) begin
      tick();
      n++;
    end
    chk(tag, n < 200, 1);
  endtask

  // Scoreboard: every cycle a valid is up, its data must match the oldest expected item.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_cmd_valid) begin
        chk("cmd_expected", cmd_q.size() != 0, 1);
        if (cmd_q.size() != 0) begin
          chk("cmd_data", cpu_cmd_data, cmd_q[0]);
          if (cpu_cmd_ready) void'(cmd_q.pop_front());
        end
      end
      if (cpu_microprog_valid) begin
        chk("mp_expected", mp_q.size() != 0, 1);
        if (mp_q.size() != 0) begin
          chk("mp_data", cpu_microprog_data, mp_q[0]);
          if (cpu_microprog_ack) void'(mp_q.pop_front());
        end
      end
      if (cpu_execute_seq_valid) begin
        chk("exec_expected", exec_pending > 0, 1);
        if (cpu_execute_seq_ready && exec_pending > 0) exec_pending--;
      end
      if (cpu_cmd_valid || cpu_microprog_valid || cpu_execute_seq_valid)
        chk("valid_onehot", $countones({cpu_cmd_valid, cpu_microprog_valid, cpu_execute_seq_valid}) == 1, 1);
    end
  end

  initial begin
    int n;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_host_ready", host_ready, 1);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_valids", {cpu_cmd_valid, cpu_microprog_valid, cpu_execute_seq_valid}, 0);
    chk("rst_data", {cpu_cmd_data, cpu_microprog_data}, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_busy", frontend_busy, 0);

    // Direct command latency
    push(2'b00, 64'hA5A5_0000_0000_0001);
    chk("t1_valid_early", cpu_cmd_valid, 0);
    tick();
    chk("t1_valid", cpu_cmd_valid, 1);
    chk("t1_data", cpu_cmd_data, 64'hA5A5_0000_0000_0001);
    tick();
    chk("t1_valid_drop", cpu_cmd_valid, 0);
    chk("t1_count", fifo_count, 0);

    // Microprogram packing with delayed ack
    push(2'b01, 64'h11);
    push(2'b01, 64'h22);
    push(2'b01, 64'h33);
    push(2'b01, 64'h44);
    n = 0;
    while (!cpu_microprog_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t2_valid_timeout", n < 50, 1);
    chk("t2_data", cpu_microprog_data, {64'h44, 64'h33, 64'h22, 64'h11});
    tick();
    chk("t2_held", cpu_microprog_valid, 1);
    tick();
    chk("t2_held2", cpu_microprog_valid, 1);
    cpu_microprog_ack = 1'b1;
    tick();
    cpu_microprog_ack = 1'b0;
    chk("t2_drop", cpu_microprog_valid, 0);
    chk("t2_drained", mp_q.size(), 0);

    // Backpressure: one word parked in CMD, eight filling the FIFO
    cpu_cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(2'b00, 64'hB000 + 64'(i));
    chk("t3_full_ready", host_ready, 0);
    chk("t3_full_count", fifo_count, 8);
    chk("t3_cmd_held", cpu_cmd_data, 64'hB000);
    cpu_cmd_ready = 1'b1;
    wait_idle("t3_drain_timeout");
    chk("t3_all_out", cmd_q.size(), 0);
    chk("t3_ready", host_ready, 1);

    // Partial microprogram aborted by an execute
    push(2'b01, 64'h1);
    push(2'b01, 64'h2);
    push(2'b10, 64'h0);
    wait_idle("t4_timeout");
    chk("t4_err", err_flags, exp_err);
    chk("t4_err_const", err_flags, 2'b01);
    chk("t4_exec_done", exec_pending, 0);

    // Reserved kind, then reset during a held command
    push(2'b11, 64'hDEAD);
    wait_idle("t5_timeout");
    chk("t5_err", err_flags, exp_err);
    chk("t5_err_const", err_flags, 2'b11);
    cpu_cmd_ready = 1'b0;
    push(2'b00, 64'hC0DE);
    n = 0;
    while (!cpu_cmd_valid && n < 50) begin
      tick();
      n++;
    end
    chk("t5_cmd_timeout", n < 50, 1);
    rst = 1'b1;
    cmd_q.delete();
    exp_err = 2'b00;
    tick();
    rst = 1'b0;
    chk("t5_rst_valids", {cpu_cmd_valid, cpu_microprog_valid, cpu_execute_seq_valid}, 0);
    chk("t5_rst_count", fifo_count, 0);
    chk("t5_rst_err", err_flags, exp_err);
    chk("t5_rst_ready", host_ready, 1);

    cpu_cmd_ready = 1'b1;
    push(2'b00, 64'h1234_5678);
    wait_idle("t6_timeout");
    chk("t6_after_reset", cmd_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
